ps2_scancode_decoder: RTL and testbench

Converts the raw PS/2 Set-2 scan-code byte stream from the keyboard receiver into ASCII characters for the VGA terminal. Tracks make/break/extended prefixes, shift/ctrl/caps-lock state, and discards keyboard control responses. Buffers decoded characters in a small FIFO with a valid/ready handshake toward the terminal character writer.

---
 rtl/ps2_scancode_decoder_pkg.sv | 57 +++++
 rtl/ps2_scancode_decoder_keymap.sv | 82 ++++++++
 rtl/ps2_scancode_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_scancode_decoder_pkg.sv
// ps2_scancode_decoder_pkg
//   Shared definitions for the PS/2 Set-2 scan-code decoder:
//   scan-code constants for prefixes and modifier keys, the extended
//   cursor-key character codes, prefix-FSM state encodings, and small
//   lookup helpers used by the top-level decoder.
//   No ports (package).
package ps2_scancode_decoder_pkg;

    // Prefix and special scan codes
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Character codes produced for the extended cursor keys
    localparam logic [7:0] CH_UP    = 8'h80;
    localparam logic [7:0] CH_DOWN  = 8'h81;
    localparam logic [7:0] CH_LEFT  = 8'h82;
    localparam logic [7:0] CH_RIGHT = 8'h83;

    // The Pause sequence is E1 followed by seven more bytes
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BRK     = 3'd1,
        ST_EXT     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } decState_e;

    // Bytes the keyboard sends as command responses or status; they
    // never correspond to a key and are discarded in the idle state.
    function automatic logic isCtrlResponse(input logic [7:0] code);
        case (code)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFF, 8'h00: isCtrlResponse = 1'b1;
            default:                                  isCtrlResponse = 1'b0;
        endcase
    endfunction

    // Extended (E0-prefixed) key lookup: returns {hit, character}.
    function automatic logic [8:0] extLookup(input logic [7:0] code);
        case (code)
            8'h75:   extLookup = {1'b1, CH_UP};
            8'h72:   extLookup = {1'b1, CH_DOWN};
            8'h6B:   extLookup = {1'b1, CH_LEFT};
            8'h74:   extLookup = {1'b1, CH_RIGHT};
            8'h5A:   extLookup = {1'b1, 8'h0D};
            8'h4A:   extLookup = {1'b1, 8'h2F};
            default: extLookup = {1'b0, 8'h00};
        endcase
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_keymap.sv
// ps2_keymap
//   Combinational US-layout keymap ROM for PS/2 Set-2 normal (non-E0) keys.
//   Ports:
//     code_i      7-bit scan code (codes >= 0x80 are filtered by the caller)
//     base_o      unshifted character, 0x00 when the code is unmapped
//     shifted_o   shifted character (uppercase for letters)
//     isLetter_o  1 when the key is a letter a-z
module ps2_keymap (
    input  logic [6:0] code_i,
    output logic [7:0] base_o,
    output logic [7:0] shifted_o,
    output logic       isLetter_o
);

    logic [15:0] entry;

    // ROM contents as {base, shifted}; keys without a shifted form
    // (tab, enter, backspace, escape, space) repeat the base code.
    always_comb begin
        entry = 16'h0000;
        case (code_i)
            7'h0D: entry = {8'h09, 8'h09};
            7'h0E: entry = {8'h60, 8'h7E};
            7'h15: entry = {8'h71, 8'h51};
            7'h16: entry = {8'h31, 8'h21};
            7'h1A: entry = {8'h7A, 8'h5A};
            7'h1B: entry = {8'h73, 8'h53};
            7'h1C: entry = {8'h61, 8'h41};
            7'h1D: entry = {8'h77, 8'h57};
            7'h1E: entry = {8'h32, 8'h40};
            7'h21: entry = {8'h63, 8'h43};
            7'h22: entry = {8'h78, 8'h58};
            7'h23: entry = {8'h64, 8'h44};
            7'h24: entry = {8'h65, 8'h45};
            7'h25: entry = {8'h34, 8'h24};
            7'h26: entry = {8'h33, 8'h23};
            7'h29: entry = {8'h20, 8'h20};
            7'h2A: entry = {8'h76, 8'h56};
            7'h2B: entry = {8'h66, 8'h46};
            7'h2C: entry = {8'h74, 8'h54};
            7'h2D: entry = {8'h72, 8'h52};
            7'h2E: entry = {8'h35, 8'h25};
            7'h31: entry = {8'h6E, 8'h4E};
            7'h32: entry = {8'h62, 8'h42};
            7'h33: entry = {8'h68, 8'h48};
            7'h34: entry = {8'h67, 8'h47};
            7'h35: entry = {8'h79, 8'h59};
            7'h36: entry = {8'h36, 8'h5E};
            7'h3A: entry = {8'h6D, 8'h4D};
            7'h3B: entry = {8'h6A, 8'h4A};
            7'h3C: entry = {8'h75, 8'h55};
            7'h3D: entry = {8'h37, 8'h26};
            7'h3E: entry = {8'h38, 8'h2A};
            7'h41: entry = {8'h2C, 8'h3C};
            7'h42: entry = {8'h6B, 8'h4B};
            7'h43: entry = {8'h69, 8'h49};
            7'h44: entry = {8'h6F, 8'h4F};
            7'h45: entry = {8'h30, 8'h29};
            7'h46: entry = {8'h39, 8'h28};
            7'h49: entry = {8'h2E, 8'h3E};
            7'h4A: entry = {8'h2F, 8'h3F};
            7'h4B: entry = {8'h6C, 8'h4C};
            7'h4C: entry = {8'h3B, 8'h3A};
            7'h4D: entry = {8'h70, 8'h50};
            7'h4E: entry = {8'h2D, 8'h5F};
            7'h52: entry = {8'h27, 8'h22};
            7'h54: entry = {8'h5B, 8'h7B};
            7'h55: entry = {8'h3D, 8'h2B};
            7'h5A: entry = {8'h0D, 8'h0D};
            7'h5B: entry = {8'h5D, 8'h7D};
            7'h5D: entry = {8'h5C, 8'h7C};
            7'h66: entry = {8'h08, 8'h08};
            7'h76: entry = {8'h1B, 8'h1B};
            default: entry = 16'h0000;
        endcase
    end

    assign base_o     = entry[15:8];
    assign shifted_o  = entry[7:0];
    assign isLetter_o = (entry[15:8] >= 8'h61) && (entry[15:8] <= 8'h7A);

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Turns the PS/2 Set-2 scan-code byte stream into ASCII characters.
//   Tracks break/extended/pause prefixes, shift/ctrl/caps-lock state, drops
//   keyboard control responses and buffers characters in a DEPTH-entry FIFO.
//   Ports:
//     clk           system clock
//     reset_n       asynchronous active-low reset
//     kbdcode       scan-code byte, sampled when kbdcodeValid is high
//     kbdcodeValid  one-cycle byte-available pulse
//     ascii         FIFO head character, 0x00 when empty
//     asciiValid    FIFO not empty
//     asciiReady    consumer takes the head when asciiValid & asciiReady
//     capsLock      caps-lock toggle state
//     overflow      one-cycle pulse after a character was dropped (FIFO full)
module ps2_scancode_decoder
    import ps2_scancode_decoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] kbdcode,
    input  logic       kbdcodeValid,
    output logic [7:0] ascii,
    output logic       asciiValid,
    input  logic       asciiReady,
    output logic       capsLock,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);

    decState_e  state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       lshift_q, lshift_d;
    logic       rshift_q, rshift_d;
    logic       lctrl_q, lctrl_d;
    logic       rctrl_q, rctrl_d;
    logic       capsHeld_q, capsHeld_d;
    logic       capsLock_q, capsLock_d;
    logic       overflow_q, overflow_d;

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wrPtr_q, rdPtr_q;

    logic [7:0] mapBase, mapShifted, mapChar;
    logic       mapIsLetter;
    logic       emitValid;
    logic [7:0] emitChar;
    logic [8:0] extHit;
    logic       fifoEmpty, fifoFull, doPop, doPush;

    ps2_keymap u_keymap (
        .code_i     (kbdcode[6:0]),
        .base_o     (mapBase),
        .shifted_o  (mapShifted),
        .isLetter_o (mapIsLetter)
    );

    assign extHit = extLookup(kbdcode);

    // Character selection for a normal key from the current modifiers.
    // Caps lock only affects letters; ctrl turns a letter into its
    // control code regardless of shift/caps.
    always_comb begin
        mapChar = mapBase;
        if (mapIsLetter) begin
            if (lctrl_q || rctrl_q) begin
                mapChar = mapShifted & 8'h1F;
            end else if ((lshift_q || rshift_q) ^ capsLock_q) begin
                mapChar = mapShifted;
            end
        end else if (lshift_q || rshift_q) begin
            mapChar = mapShifted;
        end
    end

    // Prefix FSM and modifier tracking; only moves on a valid byte.
    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        lshift_d   = lshift_q;
        rshift_d   = rshift_q;
        lctrl_d    = lctrl_q;
        rctrl_d    = rctrl_q;
        capsHeld_d = capsHeld_q;
        capsLock_d = capsLock_q;
        emitValid  = 1'b0;
        emitChar   = 8'h00;
        if (kbdcodeValid) begin
            case (state_q)
                ST_IDLE: begin
                    if (kbdcode == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else if (kbdcode == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (kbdcode == SC_PAUSE) begin
                        state_d = ST_SKIP;
                        skip_d  = PAUSE_SKIP;
                    end else if (!isCtrlResponse(kbdcode)) begin
                        if (kbdcode == SC_LSHIFT) begin
                            lshift_d = 1'b1;
                        end else if (kbdcode == SC_RSHIFT) begin
                            rshift_d = 1'b1;
                        end else if (kbdcode == SC_CTRL) begin
                            lctrl_d = 1'b1;
                        end else if (kbdcode == SC_CAPS) begin
                            // Typematic repeats arrive while held; only the first make toggles
                            if (!capsHeld_q) begin
                                capsLock_d = ~capsLock_q;
                            end
                            capsHeld_d = 1'b1;
                        end else if (!kbdcode[7] && (mapBase != 8'h00)) begin
                            emitValid = 1'b1;
                            emitChar  = mapChar;
                        end
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    if (kbdcode == SC_LSHIFT) lshift_d = 1'b0;
                    if (kbdcode == SC_RSHIFT) rshift_d = 1'b0;
                    if (kbdcode == SC_CTRL)   lctrl_d = 1'b0;
                    if (kbdcode == SC_CAPS)   capsHeld_d = 1'b0;
                end
                ST_EXT: begin
                    if (kbdcode == SC_BREAK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                        if (kbdcode == SC_CTRL) begin
                            rctrl_d = 1'b1;
                        end else if (extHit[8]) begin
                            emitValid = 1'b1;
                            emitChar  = extHit[7:0];
                        end
                    end
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                    if (kbdcode == SC_CTRL) rctrl_d = 1'b0;
                end
                ST_SKIP: begin
                    if (skip_q <= 3'd1) begin
                        state_d = ST_IDLE;
                        skip_d  = 3'd0;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    skip_d  = 3'd0;
                end
            endcase
        end
    end

    // FIFO status. A push into a full FIFO is still accepted when the
    // head is popped in the same cycle, since that slot frees up.
    assign fifoEmpty  = (wrPtr_q == rdPtr_q);
    assign fifoFull   = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
    assign doPop      = !fifoEmpty && asciiReady;
    assign doPush     = emitValid && (!fifoFull || doPop);
    assign overflow_d = emitValid && fifoFull && !doPop;

    // State, modifier and overflow registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            skip_q     <= 3'd0;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            lctrl_q    <= 1'b0;
            rctrl_q    <= 1'b0;
            capsHeld_q <= 1'b0;
            capsLock_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            lshift_q   <= lshift_d;
            rshift_q   <= rshift_d;
            lctrl_q    <= lctrl_d;
            rctrl_q    <= rctrl_d;
            capsHeld_q <= capsHeld_d;
            capsLock_q <= capsLock_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage and pointers; pointers carry an extra wrap bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q[AW-1:0]] <= emitChar;
                wrPtr_q <= wrPtr_q + {{AW{1'b0}}, 1'b1};
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    assign ascii      = fifoEmpty ? 8'h00 : mem_q[rdPtr_q[AW-1:0]];
    assign asciiValid = !fifoEmpty;
    assign capsLock   = capsLock_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder
//   Self-checking bench for ps2_scancode_decoder. Expected characters are
//   queued as key bytes are sent and compared as the consumer pops them.
module tb_ps2_scancode_decoder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] kbdcode = 8'h00;
    logic       kbdcodeValid = 1'b0;
    logic       asciiReady = 1'b0;
    logic [7:0] ascii;
    logic       asciiValid;
    logic       capsLock;
    logic       overflow;

    int         vectors = 0;
    int         miscompares = 0;
    int         ovfCount = 0;
    logic [7:0] expQ[$];
    logic [7:0] monExp;
    bit         timedOut;

    ps2_scancode_decoder #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .kbdcode      (kbdcode),
        .kbdcodeValid (kbdcodeValid),
        .ascii        (ascii),
        .asciiValid   (asciiValid),
        .asciiReady   (asciiReady),
        .capsLock     (capsLock),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Consumer side: every handshake pops the oldest expected character.
    always @(negedge clk) begin
        if (reset_n && overflow) ovfCount++;
        if (reset_n && asciiValid && asciiReady) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_char got=%02h expected none", ascii);
            end else begin
                monExp = expQ.pop_front();
                if (ascii !== monExp) begin
                    miscompares++;
                    $display("[TB] FAIL char got=%02h expected=%02h", ascii, monExp);
                end
            end
        end
    end

    // One-cycle byte pulse followed by one idle cycle.
    task automatic sendByte(input logic [7:0] b);
        @(posedge clk); #1;
        kbdcode = b;
        kbdcodeValid = 1'b1;
        @(posedge clk); #1;
        kbdcodeValid = 1'b0;
    endtask

    task automatic sendSeq(input logic [7:0] seq[$]);
        foreach (seq[i]) sendByte(seq[i]);
    endtask

    task automatic waitEmpty(output bit expired);
        expired = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (expQ.size() == 0) begin
                expired = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        asciiReady = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (ascii !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_ascii got=%02h expected=00", ascii); end
        vectors++;
        if (asciiValid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got=%0b expected=0", asciiValid); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow got=%0b expected=0", overflow); end
        vectors++;
        if (capsLock !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_caps got=%0b expected=0", capsLock); end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        asciiReady = 1'b1;
        expQ.push_back(8'h61);
        sendSeq('{8'h1C, 8'hF0, 8'h1C});
        waitEmpty(timedOut);
        vectors++;
        if (timedOut) begin miscompares++; $display("[TB] FAIL basic_timeout got=%0d pending expected=0", expQ.size()); end
        vectors++;
        if (asciiValid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_idle_valid got=%0b expected=0", asciiValid); end
    endtask

    task automatic test_shift_caps;
        expQ.push_back(8'h41);
        expQ.push_back(8'h31);
        sendSeq('{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h16});
        expQ.push_back(8'h41);
        expQ.push_back(8'h21);
        sendSeq('{8'h58, 8'hF0, 8'h58, 8'h1C, 8'h12, 8'h16, 8'hF0, 8'h12});
        waitEmpty(timedOut);
        vectors++;
        if (timedOut) begin miscompares++; $display("[TB] FAIL shift_timeout got=%0d pending expected=0", expQ.size()); end
        vectors++;
        if (capsLock !== 1'b1) begin miscompares++; $display("[TB] FAIL caps_on got=%0b expected=1", capsLock); end
    endtask

    task automatic test_caps_typematic;
        sendSeq('{8'h58, 8'h58, 8'h58, 8'hF0, 8'h58});
        @(negedge clk);
        vectors++;
        if (capsLock !== 1'b0) begin miscompares++; $display("[TB] FAIL caps_repeat got=%0b expected=0", capsLock); end
        sendByte(8'h58);
        @(negedge clk);
        vectors++;
        if (capsLock !== 1'b1) begin miscompares++; $display("[TB] FAIL caps_make got=%0b expected=1", capsLock); end
        sendSeq('{8'hF0, 8'h58, 8'h58, 8'hF0, 8'h58});
        @(negedge clk);
        vectors++;
        if (capsLock !== 1'b0) begin miscompares++; $display("[TB] FAIL caps_off got=%0b expected=0", capsLock); end
        expQ.push_back(8'h61);
        sendByte(8'h1C);
        waitEmpty(timedOut);
        vectors++;
        if (timedOut) begin miscompares++; $display("[TB] FAIL caps_timeout got=%0d pending expected=0", expQ.size()); end
    endtask

    task automatic test_ctrl;
        expQ.push_back(8'h03);
        expQ.push_back(8'h61);
        sendSeq('{8'h14, 8'h21, 8'hF0, 8'h14, 8'h1C});
        waitEmpty(timedOut);
        vectors++;
        if (timedOut) begin miscompares++; $display("[TB] FAIL ctrl_timeout got=%0d pending expected=0", expQ.size()); end
    endtask

    task automatic test_extended;
        expQ.push_back(8'h80);
        expQ.push_back(8'h82);
        sendSeq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h6B});
        expQ.push_back(8'h01);
        expQ.push_back(8'h0D);
        sendSeq('{8'hE0, 8'h14, 8'h1C, 8'hE0, 8'hF0, 8'h14, 8'hE0, 8'h5A, 8'hE0, 8'h7D});
        waitEmpty(timedOut);
        vectors++;
        if (timedOut) begin miscompares++; $display("[TB] FAIL ext_timeout got=%0d pending expected=0", expQ.size()); end
    endtask

    task automatic test_pause;
        expQ.push_back(8'h61);
        sendSeq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C});
        waitEmpty(timedOut);
        vectors++;
        if (timedOut) begin miscompares++; $display("[TB] FAIL pause_timeout got=%0d pending expected=0", expQ.size()); end
    endtask

    task automatic test_ctrl_responses;
        sendSeq('{8'hAA, 8'hFA, 8'hEE});
        repeat (2) @(negedge clk);
        vectors++;
        if (asciiValid !== 1'b0) begin miscompares++; $display("[TB] FAIL response_valid got=%0b expected=0", asciiValid); end
        expQ.push_back(8'h7A);
        sendByte(8'h1A);
        waitEmpty(timedOut);
        vectors++;
        if (timedOut) begin miscompares++; $display("[TB] FAIL response_timeout got=%0d pending expected=0", expQ.size()); end
    endtask

    task automatic test_overflow;
        asciiReady = 1'b0;
        ovfCount = 0;
        expQ.push_back(8'h61);
        expQ.push_back(8'h62);
        expQ.push_back(8'h63);
        expQ.push_back(8'h64);
        sendSeq('{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B});
        repeat (2) @(negedge clk);
        vectors++;
        if (ovfCount !== 2) begin miscompares++; $display("[TB] FAIL overflow_count got=%0d expected=2", ovfCount); end
        vectors++;
        if (ascii !== 8'h61) begin miscompares++; $display("[TB] FAIL full_head got=%02h expected=61", ascii); end
        // pop and push in the same cycle while full
        @(posedge clk); #1;
        expQ.push_back(8'h67);
        kbdcode = 8'h34;
        kbdcodeValid = 1'b1;
        asciiReady = 1'b1;
        @(posedge clk); #1;
        kbdcodeValid = 1'b0;
        asciiReady = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (ovfCount !== 2) begin miscompares++; $display("[TB] FAIL popPush_overflow got=%0d expected=2", ovfCount); end
        vectors++;
        if (ascii !== 8'h62) begin miscompares++; $display("[TB] FAIL popPush_head got=%02h expected=62", ascii); end
        asciiReady = 1'b1;
        waitEmpty(timedOut);
        vectors++;
        if (timedOut) begin miscompares++; $display("[TB] FAIL overflow_timeout got=%0d pending expected=0", expQ.size()); end
    endtask

    task automatic test_reset_mid;
        asciiReady = 1'b0;
        sendSeq('{8'h58, 8'hF0, 8'h58, 8'h1C, 8'hF0});
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (asciiValid !== 1'b0) begin miscompares++; $display("[TB] FAIL midReset_valid got=%0b expected=0", asciiValid); end
        vectors++;
        if (ascii !== 8'h00) begin miscompares++; $display("[TB] FAIL midReset_ascii got=%02h expected=00", ascii); end
        vectors++;
        if (capsLock !== 1'b0) begin miscompares++; $display("[TB] FAIL midReset_caps got=%0b expected=0", capsLock); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL midReset_overflow got=%0b expected=0", overflow); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        asciiReady = 1'b1;
        expQ.push_back(8'h61);
        sendByte(8'h1C);
        waitEmpty(timedOut);
        vectors++;
        if (timedOut) begin miscompares++; $display("[TB] FAIL midReset_timeout got=%0d pending expected=0", expQ.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift_caps();
        test_caps_typematic();
        test_ctrl();
        test_extended();
        test_pause();
        test_ctrl_responses();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
